// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I(M) core: opcodes, mux selects,
// ALU op classes, PC sources, FSM states and the one-hot instruction class.
package riscv_pkg;

  localparam logic [6:0] INST_TYPE_R = 7'b0110011;
  localparam logic [6:0] INST_TYPE_I = 7'b0010011;
  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;
  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] FROM_ALU = 2'd0;
  localparam logic [1:0] FROM_MEM = 2'd1;
  localparam logic [1:0] FROM_IMM = 2'd2;
  localparam logic [1:0] FROM_PC  = 2'd3;

  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_B   = 2'd1;
  localparam logic [1:0] ALU_OP_R   = 2'd2;
  localparam logic [1:0] ALU_OP_I   = 2'd3;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_JUMPR  = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MULDIV = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // Bit positions inside the one-hot instruction class vector.
  localparam int CLS_R       = 0;
  localparam int CLS_I       = 1;
  localparam int CLS_L       = 2;
  localparam int CLS_S       = 3;
  localparam int CLS_B       = 4;
  localparam int CLS_JAL     = 5;
  localparam int CLS_JALR    = 6;
  localparam int CLS_LUI     = 7;
  localparam int CLS_AUIPC   = 8;
  localparam int CLS_M       = 9;
  localparam int CLS_ILLEGAL = 10;
  localparam int CLS_NUM     = 11;

  typedef logic [CLS_NUM-1:0] inst_class_t;

endpackage

// File: rtl/inst_classifier.sv
// Combinational opcode/funct7 classifier producing a one-hot instruction class.
// M-extension encodings fold into ILLEGAL when the core is built without M.
module inst_classifier
  import riscv_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0]  opcode,
  input  logic [6:0]  funct7,
  output inst_class_t inst_class
);

  localparam int M_SLOT = ENABLE_M ? CLS_M : CLS_ILLEGAL;

  always_comb begin
    inst_class = '0;
    case (opcode)
      INST_TYPE_R: begin
        if (funct7 == FUNCT7_MULDIV) inst_class[M_SLOT] = 1'b1;
        else                         inst_class[CLS_R]  = 1'b1;
      end
      INST_TYPE_I: inst_class[CLS_I]       = 1'b1;
      INST_TYPE_L: inst_class[CLS_L]       = 1'b1;
      INST_TYPE_S: inst_class[CLS_S]       = 1'b1;
      INST_TYPE_B: inst_class[CLS_B]       = 1'b1;
      INST_JAL:    inst_class[CLS_JAL]     = 1'b1;
      INST_JALR:   inst_class[CLS_JALR]    = 1'b1;
      INST_LUI:    inst_class[CLS_LUI]     = 1'b1;
      INST_AUIPC:  inst_class[CLS_AUIPC]   = 1'b1;
      default:     inst_class[CLS_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB/MULDIV/TRAP driving datapath
// selects and enables; memory waits stretch FETCH/MEM one cycle per idle ready.
module multicycle_control_unit
  import riscv_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic [1:0] alu_op,
  output logic       mul_start,
  output logic       reg_write,
  output logic [1:0] reg_src,
  output logic       illegal_inst,
  output logic [2:0] state
);

  localparam int              CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  inst_class_t      cls;

  inst_classifier #(
    .ENABLE_M (ENABLE_M)
  ) u_classifier (
    .opcode     (opcode),
    .funct7     (funct7),
    .inst_class (cls)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls[CLS_ILLEGAL]) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else if (cls[CLS_M]) begin
          state_d = ST_MULDIV;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls[CLS_B])                   state_d = ST_FETCH;
        else if (cls[CLS_L] || cls[CLS_S]) state_d = ST_MEM;
        else                              state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) state_d = cls[CLS_S] ? ST_FETCH : ST_WB;
      end
      ST_MULDIV: begin
        if (cnt_q == '0) state_d = ST_WB;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: begin
        state_d   = ST_TRAP;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Gating on rst makes every request/enable fall the instant reset rises,
  // so an interrupted access never completes a PC or register update.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PC4;
    alu_src1  = 1'b0;
    alu_src2  = 1'b0;
    alu_op    = ALU_OP_ADD;
    mul_start = 1'b0;
    reg_write = 1'b0;
    reg_src   = FROM_ALU;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        ST_DECODE: begin
          mul_start = cls[CLS_M];
        end
        ST_EXEC: begin
          // Branches use the ALU for the rs1/rs2 compare; the target adder is separate.
          alu_src1 = cls[CLS_AUIPC] | cls[CLS_JAL];
          alu_src2 = cls[CLS_I] | cls[CLS_L] | cls[CLS_S] | cls[CLS_AUIPC]
                   | cls[CLS_JAL] | cls[CLS_JALR] | cls[CLS_LUI];
          if (cls[CLS_R])      alu_op = ALU_OP_R;
          else if (cls[CLS_I]) alu_op = ALU_OP_I;
          else if (cls[CLS_B]) alu_op = ALU_OP_B;
          if (cls[CLS_B]) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
          end
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_we   = cls[CLS_S];
          pc_write = mem_ready & cls[CLS_S];
        end
        ST_MULDIV: begin
          alu_op = ALU_OP_R;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (cls[CLS_L])                       reg_src = FROM_MEM;
          else if (cls[CLS_LUI])                reg_src = FROM_IMM;
          else if (cls[CLS_JAL] || cls[CLS_JALR]) reg_src = FROM_PC;
          if (cls[CLS_JAL])       pc_src = PC_SRC_JUMP;
          else if (cls[CLS_JALR]) pc_src = PC_SRC_JUMPR;
        end
        default: ;
      endcase
    end
  end

  assign illegal_inst = illegal_q;
  assign state        = state_q;

endmodule
